decode_queue: RTL and testbench

//  Parametrised successor of the single-slot decoder: a DEPTH-entry instruction FIFO between fetch and dispatch,

---
 rtl/decode_queue_pkg.sv | 65 ++++++
 rtl/decode_queue_core.sv | 161 ++++++++++++++++
 rtl/decode_queue.sv | 144 ++++++++++++++
 tb/tb_decode_queue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared types, RV32 field constants and operation codes for the decode queue.
// Optional macro DECODE_MUL_EN adds the RV32M operation codes.
package decode_queue_pkg;

    localparam int OP_W = 6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND
`ifdef DECODE_MUL_EN
        , OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
`endif
    } op_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pt;
    } fetch_entry_t;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_queue_core.sv
// decode_core: purely combinational RV32I(+M when DECODE_MUL_EN) instruction decoder.
// Anything unrecognised collapses to a NOP with zero immediate and x0 registers.
module decode_core
    import decode_queue_pkg::*;
(
    input  logic [31:0]     inst,
    output logic [OP_W-1:0] op,
    output logic [31:0]     imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            lsq
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    op_e        op_sel;
    logic [31:0] imm_sel;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic       lsq_sel;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        op_sel  = OP_NOP;
        imm_sel = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        lsq_sel = 1'b0;
        case (opcode)
            OPC_LUI:   begin op_sel = OP_LUI;   imm_sel = imm_u(inst); use_rd = 1'b1; end
            OPC_AUIPC: begin op_sel = OP_AUIPC; imm_sel = imm_u(inst); use_rd = 1'b1; end
            OPC_JAL:   begin op_sel = OP_JAL;   imm_sel = imm_j(inst); use_rd = 1'b1; end
            OPC_JALR: begin
                if (funct3 == 3'b000) op_sel = OP_JALR;
                imm_sel = imm_i(inst);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  op_sel = OP_BEQ;
                    3'b001:  op_sel = OP_BNE;
                    3'b100:  op_sel = OP_BLT;
                    3'b101:  op_sel = OP_BGE;
                    3'b110:  op_sel = OP_BLTU;
                    3'b111:  op_sel = OP_BGEU;
                    default: op_sel = OP_NOP;
                endcase
                imm_sel = imm_b(inst);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000:  op_sel = OP_LB;
                    3'b001:  op_sel = OP_LH;
                    3'b010:  op_sel = OP_LW;
                    3'b100:  op_sel = OP_LBU;
                    3'b101:  op_sel = OP_LHU;
                    default: op_sel = OP_NOP;
                endcase
                imm_sel = imm_i(inst);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                lsq_sel = 1'b1;
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000:  op_sel = OP_SB;
                    3'b001:  op_sel = OP_SH;
                    3'b010:  op_sel = OP_SW;
                    default: op_sel = OP_NOP;
                endcase
                imm_sel = imm_s(inst);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                lsq_sel = 1'b1;
            end
            OPC_OPIMM: begin
                imm_sel = imm_i(inst);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                case (funct3)
                    3'b000: op_sel = OP_ADDI;
                    3'b010: op_sel = OP_SLTI;
                    3'b011: op_sel = OP_SLTIU;
                    3'b100: op_sel = OP_XORI;
                    3'b110: op_sel = OP_ORI;
                    3'b111: op_sel = OP_ANDI;
                    3'b001: begin
                        if (funct7 == F7_BASE) op_sel = OP_SLLI;
                        imm_sel = {27'b0, inst[24:20]};
                    end
                    default: begin
                        if (funct7 == F7_BASE)     op_sel = OP_SRLI;
                        else if (funct7 == F7_ALT) op_sel = OP_SRAI;
                        imm_sel = {27'b0, inst[24:20]};
                    end
                endcase
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  op_sel = OP_ADD;
                        3'b001:  op_sel = OP_SLL;
                        3'b010:  op_sel = OP_SLT;
                        3'b011:  op_sel = OP_SLTU;
                        3'b100:  op_sel = OP_XOR;
                        3'b101:  op_sel = OP_SRL;
                        3'b110:  op_sel = OP_OR;
                        default: op_sel = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      op_sel = OP_SUB;
                    else if (funct3 == 3'b101) op_sel = OP_SRA;
                end
`ifdef DECODE_MUL_EN
                else if (funct7 == F7_MULDIV) begin
                    case (funct3)
                        3'b000:  op_sel = OP_MUL;
                        3'b001:  op_sel = OP_MULH;
                        3'b010:  op_sel = OP_MULHSU;
                        3'b011:  op_sel = OP_MULHU;
                        3'b100:  op_sel = OP_DIV;
                        3'b101:  op_sel = OP_DIVU;
                        3'b110:  op_sel = OP_REM;
                        default: op_sel = OP_REMU;
                    endcase
                end
`endif
            end
            default: op_sel = OP_NOP;
        endcase
        // Invalid encodings still flow to the ROB, but as a clean NOP.
        if (op_sel == OP_NOP) begin
            imm_sel = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_rd  = 1'b0;
            lsq_sel = 1'b0;
        end
    end

    assign op  = op_sel;
    assign imm = imm_sel;
    assign rs1 = use_rs1 ? inst[19:15] : ZERO_REG;
    assign rs2 = use_rs2 ? inst[24:20] : ZERO_REG;
    assign rd  = use_rd  ? inst[11:7]  : ZERO_REG;
    assign lsq = lsq_sel;

endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry fetch FIFO feeding one registered decode stage, with flush.
// Optional macro DECODE_MUL_EN enables RV32M decode inside decode_core.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_flush,
    input  logic             in_fetch_valid,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic             in_predicted_taken,
    output logic             out_fetch_ready,
    output logic             out_dec_valid,
    input  logic             in_dispatch_ready,
    output logic [OP_W-1:0]  out_op,
    output logic [31:0]      out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_lsqueue_ena,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             out_predicted_taken,
    output logic [PTR_W:0]   out_count
);

    fetch_entry_t fifo_mem [DEPTH];
    fetch_entry_t head_entry;

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             dec_valid_reg;
    logic             push;
    logic             load;

    logic [OP_W-1:0]  core_op;
    logic [31:0]      core_imm;
    logic [4:0]       core_rs1;
    logic [4:0]       core_rs2;
    logic [4:0]       core_rd;
    logic             core_lsq;

    logic [OP_W-1:0]  op_reg;
    logic [31:0]      imm_reg;
    logic [4:0]       rs1_reg;
    logic [4:0]       rs2_reg;
    logic [4:0]       rd_reg;
    logic             lsq_reg;
    logic [31:0]      pc_reg;
    logic [31:0]      inst_reg;
    logic             pt_reg;

    // Ready depends only on occupancy so dispatch never reaches fetch combinationally.
    assign out_fetch_ready = (count_reg != (PTR_W+1)'(DEPTH));
    assign push = in_fetch_valid && out_fetch_ready;
    assign load = (count_reg != '0) && (!dec_valid_reg || in_dispatch_ready);
    assign head_entry = fifo_mem[head_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push && !rst && !in_flush && (tail_reg == PTR_W'(gi))) begin
                    fifo_mem[gi] <= '{inst: in_inst, pc: in_pc, pt: in_predicted_taken};
                end
            end
        end
    endgenerate

    decode_core u_core (
        .inst (head_entry.inst),
        .op   (core_op),
        .imm  (core_imm),
        .rs1  (core_rs1),
        .rs2  (core_rs2),
        .rd   (core_rd),
        .lsq  (core_lsq)
    );

    always_comb begin
        count_next = count_reg;
        if (push && !load) begin
            count_next = count_reg + (PTR_W+1)'(1);
        end else if (!push && load) begin
            count_next = count_reg - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || in_flush) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            dec_valid_reg <= 1'b0;
            op_reg        <= OP_NOP;
            imm_reg       <= '0;
            rs1_reg       <= ZERO_REG;
            rs2_reg       <= ZERO_REG;
            rd_reg        <= ZERO_REG;
            lsq_reg       <= 1'b0;
            pc_reg        <= '0;
            inst_reg      <= '0;
            pt_reg        <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (load) begin
                head_reg      <= head_reg + PTR_W'(1);
                dec_valid_reg <= 1'b1;
                op_reg        <= core_op;
                imm_reg       <= core_imm;
                rs1_reg       <= core_rs1;
                rs2_reg       <= core_rs2;
                rd_reg        <= core_rd;
                lsq_reg       <= core_lsq;
                pc_reg        <= head_entry.pc;
                inst_reg      <= head_entry.inst;
                pt_reg        <= head_entry.pt;
            end else if (in_dispatch_ready) begin
                dec_valid_reg <= 1'b0;
            end
        end
    end

    assign out_dec_valid       = dec_valid_reg;
    assign out_op              = op_reg;
    assign out_imm             = imm_reg;
    assign out_rs1             = rs1_reg;
    assign out_rs2             = rs2_reg;
    assign out_rd              = rd_reg;
    assign out_lsqueue_ena     = lsq_reg;
    assign out_pc              = pc_reg;
    assign out_inst            = inst_reg;
    assign out_predicted_taken = pt_reg;
    assign out_count           = count_reg;

endmodule

// File: tb/tb_decode_queue.sv
// Randomised bench for decode_queue: a queue-based reference model plus a table-driven decoder.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, in_flush, in_fetch_valid, in_predicted_taken, in_dispatch_ready;
    logic [31:0]     in_inst, in_pc;
    logic            out_fetch_ready, out_dec_valid, out_lsqueue_ena, out_predicted_taken;
    logic [OP_W-1:0] out_op;
    logic [31:0]     out_imm, out_pc, out_inst;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [PTR_W:0]  out_count;

    decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .in_flush(in_flush), .in_fetch_valid(in_fetch_valid),
        .in_inst(in_inst), .in_pc(in_pc), .in_predicted_taken(in_predicted_taken),
        .out_fetch_ready(out_fetch_ready), .out_dec_valid(out_dec_valid),
        .in_dispatch_ready(in_dispatch_ready), .out_op(out_op), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_lsqueue_ena(out_lsqueue_ena), .out_pc(out_pc), .out_inst(out_inst),
        .out_predicted_taken(out_predicted_taken), .out_count(out_count)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pt;
    } ent_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [31:0]     imm;
        logic [4:0]      rs1, rs2, rd;
        logic            lsq;
    } uop_t;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q[$];
    logic m_vld;
    uop_t m_uop;
    ent_t m_ent;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef enum int { K_NONE, K_R, K_I, K_SH, K_L, K_S, K_B, K_U, K_J } kind_e;

    // Reference decode written from the RV32 encoding tables.
    function automatic uop_t ref_decode(input logic [31:0] w);
        uop_t  e;
        kind_e k;
        op_e   o;
        e = '0;
        k = K_NONE;
        o = OP_NOP;
        casez (w)
            32'b????????????????????_?????_0110111: begin o = OP_LUI;   k = K_U; end
            32'b????????????????????_?????_0010111: begin o = OP_AUIPC; k = K_U; end
            32'b????????????????????_?????_1101111: begin o = OP_JAL;   k = K_J; end
            32'b????????????_?????_000_?????_1100111: begin o = OP_JALR; k = K_I; end
            32'b???????_?????_?????_000_?????_1100011: begin o = OP_BEQ;  k = K_B; end
            32'b???????_?????_?????_001_?????_1100011: begin o = OP_BNE;  k = K_B; end
            32'b???????_?????_?????_100_?????_1100011: begin o = OP_BLT;  k = K_B; end
            32'b???????_?????_?????_101_?????_1100011: begin o = OP_BGE;  k = K_B; end
            32'b???????_?????_?????_110_?????_1100011: begin o = OP_BLTU; k = K_B; end
            32'b???????_?????_?????_111_?????_1100011: begin o = OP_BGEU; k = K_B; end
            32'b????????????_?????_000_?????_0000011: begin o = OP_LB;  k = K_L; end
            32'b????????????_?????_001_?????_0000011: begin o = OP_LH;  k = K_L; end
            32'b????????????_?????_010_?????_0000011: begin o = OP_LW;  k = K_L; end
            32'b????????????_?????_100_?????_0000011: begin o = OP_LBU; k = K_L; end
            32'b????????????_?????_101_?????_0000011: begin o = OP_LHU; k = K_L; end
            32'b???????_?????_?????_000_?????_0100011: begin o = OP_SB; k = K_S; end
            32'b???????_?????_?????_001_?????_0100011: begin o = OP_SH; k = K_S; end
            32'b???????_?????_?????_010_?????_0100011: begin o = OP_SW; k = K_S; end
            32'b????????????_?????_000_?????_0010011: begin o = OP_ADDI;  k = K_I; end
            32'b????????????_?????_010_?????_0010011: begin o = OP_SLTI;  k = K_I; end
            32'b????????????_?????_011_?????_0010011: begin o = OP_SLTIU; k = K_I; end
            32'b????????????_?????_100_?????_0010011: begin o = OP_XORI;  k = K_I; end
            32'b????????????_?????_110_?????_0010011: begin o = OP_ORI;   k = K_I; end
            32'b????????????_?????_111_?????_0010011: begin o = OP_ANDI;  k = K_I; end
            32'b0000000_?????_?????_001_?????_0010011: begin o = OP_SLLI; k = K_SH; end
            32'b0000000_?????_?????_101_?????_0010011: begin o = OP_SRLI; k = K_SH; end
            32'b0100000_?????_?????_101_?????_0010011: begin o = OP_SRAI; k = K_SH; end
            32'b0000000_?????_?????_000_?????_0110011: begin o = OP_ADD;  k = K_R; end
            32'b0000000_?????_?????_001_?????_0110011: begin o = OP_SLL;  k = K_R; end
            32'b0000000_?????_?????_010_?????_0110011: begin o = OP_SLT;  k = K_R; end
            32'b0000000_?????_?????_011_?????_0110011: begin o = OP_SLTU; k = K_R; end
            32'b0000000_?????_?????_100_?????_0110011: begin o = OP_XOR;  k = K_R; end
            32'b0000000_?????_?????_101_?????_0110011: begin o = OP_SRL;  k = K_R; end
            32'b0000000_?????_?????_110_?????_0110011: begin o = OP_OR;   k = K_R; end
            32'b0000000_?????_?????_111_?????_0110011: begin o = OP_AND;  k = K_R; end
            32'b0100000_?????_?????_000_?????_0110011: begin o = OP_SUB;  k = K_R; end
            32'b0100000_?????_?????_101_?????_0110011: begin o = OP_SRA;  k = K_R; end
`ifdef DECODE_MUL_EN
            32'b0000001_?????_?????_000_?????_0110011: begin o = OP_MUL;    k = K_R; end
            32'b0000001_?????_?????_001_?????_0110011: begin o = OP_MULH;   k = K_R; end
            32'b0000001_?????_?????_010_?????_0110011: begin o = OP_MULHSU; k = K_R; end
            32'b0000001_?????_?????_011_?????_0110011: begin o = OP_MULHU;  k = K_R; end
            32'b0000001_?????_?????_100_?????_0110011: begin o = OP_DIV;    k = K_R; end
            32'b0000001_?????_?????_101_?????_0110011: begin o = OP_DIVU;   k = K_R; end
            32'b0000001_?????_?????_110_?????_0110011: begin o = OP_REM;    k = K_R; end
            32'b0000001_?????_?????_111_?????_0110011: begin o = OP_REMU;   k = K_R; end
`endif
            default: begin o = OP_NOP; k = K_NONE; end
        endcase
        e.op = o;
        case (k)
            K_R:  begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; end
            K_I:  begin e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = 32'($signed(w) >>> 20); end
            K_SH: begin e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = 32'(w[24:20]); end
            K_L:  begin e.rs1 = w[19:15]; e.rd = w[11:7]; e.lsq = 1'b1;
                        e.imm = 32'($signed(w) >>> 20); end
            K_S:  begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.lsq = 1'b1;
                        e.imm = (32'($signed(w) >>> 20) & 32'hFFFF_FFE0) | 32'(w[11:7]); end
            K_B:  begin e.rs1 = w[19:15]; e.rs2 = w[24:20];
                        e.imm = (32'($signed(w) >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11)
                              | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1); end
            K_U:  begin e.rd = w[11:7]; e.imm = w & 32'hFFFF_F000; end
            K_J:  begin e.rd = w[11:7];
                        e.imm = (32'($signed(w) >>> 11) & 32'hFFF0_0000) | (32'(w[19:12]) << 12)
                              | (32'(w[20]) << 11) | (32'(w[30:21]) << 1); end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  opcs [9];
        logic [6:0]  f7s [4];
        int          k;
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                 OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
        f7s  = '{F7_BASE, F7_ALT, F7_MULDIV, 7'h55};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) begin
            w[6:0] = opcs[k];
            if (k >= 7 && $urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
        end
        return w;
    endfunction

    task automatic compare_all();
        check_eq("count",  64'(out_count),       64'(q.size()));
        check_eq("ready",  64'(out_fetch_ready), 64'(q.size() < DEPTH));
        check_eq("valid",  64'(out_dec_valid),   64'(m_vld));
        check_eq("op",     64'(out_op),          64'(m_uop.op));
        check_eq("imm",    64'(out_imm),         64'(m_uop.imm));
        check_eq("rs1",    64'(out_rs1),         64'(m_uop.rs1));
        check_eq("rs2",    64'(out_rs2),         64'(m_uop.rs2));
        check_eq("rd",     64'(out_rd),          64'(m_uop.rd));
        check_eq("lsq",    64'(out_lsqueue_ena), 64'(m_uop.lsq));
        check_eq("pc",     64'(out_pc),          64'(m_ent.pc));
        check_eq("inst",   64'(out_inst),        64'(m_ent.inst));
        check_eq("pt",     64'(out_predicted_taken), 64'(m_ent.pt));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic r, input logic fl, input logic fv, input logic [31:0] inst,
                         input logic [31:0] pc, input logic pt, input logic dr);
        logic can_push, do_load;
        ent_t e;
        rst = r; in_flush = fl; in_fetch_valid = fv; in_inst = inst;
        in_pc = pc; in_predicted_taken = pt; in_dispatch_ready = dr;
        @(posedge clk);
        #1;
        if (r || fl) begin
            q.delete();
            m_vld = 1'b0;
            m_uop = '0;
            m_ent = '0;
        end else begin
            can_push = fv && (q.size() < DEPTH);
            do_load  = (q.size() != 0) && (!m_vld || dr);
            if (do_load) begin
                e = q.pop_front();
                m_ent = e;
                m_uop = ref_decode(e.inst);
                m_vld = 1'b1;
            end else if (dr) begin
                m_vld = 1'b0;
            end
            if (can_push) q.push_back('{inst: inst, pc: pc, pt: pt});
        end
        compare_all();
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || m_vld) && n < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        check_eq("drain_done", 64'(q.size() != 0 || m_vld), 64'(0));
    endtask

    initial begin
        m_vld = 1'b0; m_uop = '0; m_ent = '0;
        rst = 1'b1; in_flush = 1'b0; in_fetch_valid = 1'b0; in_inst = '0;
        in_pc = '0; in_predicted_taken = 1'b0; in_dispatch_ready = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("reset_op", 64'(out_op), 64'(OP_NOP));

        // ADDI x1,x0,5 into an empty queue: visible after the second edge.
        cycle(1'b0, 1'b0, 1'b1, 32'h00500093, 32'h100, 1'b0, 1'b1);
        check_eq("addi_lat1_valid", 64'(out_dec_valid), 64'(0));
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_eq("addi_valid", 64'(out_dec_valid), 64'(1));
        check_eq("addi_op",    64'(out_op),  64'(OP_ADDI));
        check_eq("addi_imm",   64'(out_imm), 64'(5));
        check_eq("addi_rd",    64'(out_rd),  64'(1));

        // SRAI x2,x1,3
        cycle(1'b0, 1'b0, 1'b1, 32'h4030D113, 32'h104, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_eq("srai_op",  64'(out_op),  64'(OP_SRAI));
        check_eq("srai_imm", 64'(out_imm), 64'(3));
        check_eq("srai_rs1", 64'(out_rs1), 64'(1));
        check_eq("srai_rd",  64'(out_rd),  64'(2));
        drain();

        // Fill with dispatch stalled, then release one per cycle.
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 1'b1, rand_inst(), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
        check_eq("full_count", 64'(out_count), 64'(4));
        check_eq("full_ready", 64'(out_fetch_ready), 64'(0));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        drain();

        // Flush with three buffered and a valid decode register, concurrent push.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 1'b1, rand_inst(), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        check_eq("preflush_count", 64'(out_count), 64'(3));
        cycle(1'b0, 1'b1, 1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0);
        check_eq("flush_count", 64'(out_count), 64'(0));
        check_eq("flush_valid", 64'(out_dec_valid), 64'(0));
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_eq("flush_drop_valid", 64'(out_dec_valid), 64'(0));

        // MUL x3,x1,x2
        cycle(1'b0, 1'b0, 1'b1, 32'h022081B3, 32'h500, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef DECODE_MUL_EN
        check_eq("mul_op", 64'(out_op), 64'(OP_MUL));
        check_eq("mul_rd", 64'(out_rd), 64'(3));
`else
        check_eq("mul_op", 64'(out_op), 64'(OP_NOP));
        check_eq("mul_rd", 64'(out_rd), 64'(0));
`endif
        drain();

        // Reset mid-stream with two buffered and the output held.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1, rand_inst(), 32'h600 + 32'(i * 4), 1'b1, 1'b0);
        check_eq("prerst_count", 64'(out_count), 64'(2));
        cycle(1'b1, 1'b0, 1'b1, 32'h00500093, 32'h700, 1'b0, 1'b0);
        check_eq("rst_ready", 64'(out_fetch_ready), 64'(1));
        check_eq("rst_valid", 64'(out_dec_valid), 64'(0));
        check_eq("rst_pc",    64'(out_pc), 64'(0));

        // Random traffic with varying dispatch pressure.
        for (int i = 0; i < 3000; i++) begin
            int pdr;
            pdr = ((i / 200) % 2 == 0) ? 70 : 25;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 99) < 75, rand_inst(), $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 99) < pdr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
